// File: rtl/mig_ui_responder.sv
// Responder-side model of the 7-series MIG app_* user interface.
// Commands and write beats are queued, executed in order against an on-chip
// burst RAM, and read data is returned through a fixed-latency pipe.
module mig_ui_responder #(
    parameter int unsigned ADDR_WIDTH   = 29,
    parameter int unsigned DATA_WIDTH   = 256,
    parameter int unsigned MASK_WIDTH   = 32,
    parameter int unsigned DEPTH_LOG2   = 6,
    parameter int unsigned RD_LATENCY   = 4,
    parameter int unsigned CALIB_CYCLES = 64,
    parameter int unsigned BUSY_PERIOD  = 0
) (
    input  logic                  ui_clk,
    input  logic                  ui_clk_sync_rst,
    input  logic [ADDR_WIDTH-1:0] app_addr,
    input  logic [2:0]            app_cmd,
    input  logic                  app_en,
    input  logic [DATA_WIDTH-1:0] app_wdf_data,
    input  logic [MASK_WIDTH-1:0] app_wdf_mask,
    input  logic                  app_wdf_wren,
    input  logic                  app_wdf_end,
    output logic                  app_rdy,
    output logic                  app_wdf_rdy,
    output logic [DATA_WIDTH-1:0] app_rd_data,
    output logic                  app_rd_data_valid,
    output logic                  app_rd_data_end,
    output logic                  init_calib_complete,
    output logic                  err_cmd,
    output logic                  err_wdf
);

    localparam int unsigned DEPTH   = 1 << DEPTH_LOG2;
    localparam int unsigned CAL_W   = $clog2(CALIB_CYCLES + 1);
    localparam int unsigned THR_W   = (BUSY_PERIOD > 1) ? $clog2(BUSY_PERIOD) : 1;
    localparam int unsigned THR_MAX = (BUSY_PERIOD > 1) ? BUSY_PERIOD - 1 : 0;
    localparam logic [2:0]  CMD_WR  = 3'b000;
    localparam logic [2:0]  CMD_RD  = 3'b001;

    // Storage: command queue, write-data queue, burst RAM
    logic [2:0]            cq_cmd_q  [4];
    logic [DEPTH_LOG2-1:0] cq_idx_q  [4];
    logic [DATA_WIDTH-1:0] wq_data_q [4];
    logic [MASK_WIDTH-1:0] wq_mask_q [4];
    logic [DATA_WIDTH-1:0] mem_q     [DEPTH];

    // Control state
    logic [1:0]            cq_rd_q, cq_rd_d, cq_wr_q, cq_wr_d;
    logic [2:0]            cq_cnt_q, cq_cnt_d;
    logic [1:0]            wq_rd_q, wq_rd_d, wq_wr_q, wq_wr_d;
    logic [2:0]            wq_cnt_q, wq_cnt_d;
    logic [CAL_W-1:0]      cal_cnt_q, cal_cnt_d;
    logic                  calib_q, calib_d;
    logic [THR_W-1:0]      thr_q, thr_d;
    logic                  rdy_q, rdy_d;
    logic                  wdf_rdy_q, wdf_rdy_d;
    logic                  err_cmd_q, err_cmd_d;
    logic                  err_wdf_q, err_wdf_d;
    logic                  rd_vld_q, rd_vld_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  pv_q [RD_LATENCY];
    logic                  pv_d [RD_LATENCY];
    logic [DATA_WIDTH-1:0] pd_q [RD_LATENCY];
    logic [DATA_WIDTH-1:0] pd_d [RD_LATENCY];

    // Combinational handshake / execution decode
    logic                  cmd_push, wd_push, wd_bad;
    logic                  head_vld, exec_wr, exec_rd, cq_pop;
    logic [2:0]            head_cmd;
    logic [DEPTH_LOG2-1:0] head_idx, in_idx;
    logic                  thr_hit;
    logic                  unused_addr_bits;

    // Address bits outside the word index are don't-care
    assign unused_addr_bits = ^{app_addr[2:0], app_addr[ADDR_WIDTH-1:3+DEPTH_LOG2]};
    assign in_idx           = app_addr[3 +: DEPTH_LOG2];

    // Next-state logic for queues, calibration, throttle, read pipe and flags
    always_comb begin
        cmd_push = app_en && rdy_q;
        wd_push  = app_wdf_wren && wdf_rdy_q && app_wdf_end;
        wd_bad   = app_wdf_wren && wdf_rdy_q && !app_wdf_end;
        head_vld = (cq_cnt_q != 3'd0);
        head_cmd = cq_cmd_q[cq_rd_q];
        head_idx = cq_idx_q[cq_rd_q];
        exec_wr  = head_vld && (head_cmd == CMD_WR) && (wq_cnt_q != 3'd0);
        exec_rd  = head_vld && (head_cmd == CMD_RD);
        cq_pop   = head_vld && ((head_cmd != CMD_WR) || (wq_cnt_q != 3'd0));

        cq_wr_d  = 2'(cq_wr_q + 2'(cmd_push));
        cq_rd_d  = 2'(cq_rd_q + 2'(cq_pop));
        cq_cnt_d = 3'(cq_cnt_q + 3'(cmd_push) - 3'(cq_pop));
        wq_wr_d  = 2'(wq_wr_q + 2'(wd_push));
        wq_rd_d  = 2'(wq_rd_q + 2'(exec_wr));
        wq_cnt_d = 3'(wq_cnt_q + 3'(wd_push) - 3'(exec_wr));

        cal_cnt_d = cal_cnt_q;
        calib_d   = calib_q;
        if (!calib_q) begin
            cal_cnt_d = CAL_W'(cal_cnt_q + 1'b1);
            if (cal_cnt_q == CAL_W'(CALIB_CYCLES - 1)) begin
                calib_d = 1'b1;
            end
        end

        thr_d   = (thr_q == THR_W'(THR_MAX)) ? '0 : THR_W'(thr_q + 1'b1);
        thr_hit = (BUSY_PERIOD > 1) && (thr_d == THR_W'(THR_MAX));

        rdy_d     = calib_d && (cq_cnt_d != 3'd4) && !thr_hit;
        wdf_rdy_d = calib_d && (wq_cnt_d != 3'd4);

        err_cmd_d = err_cmd_q || (cmd_push && (app_cmd != CMD_WR) && (app_cmd != CMD_RD));
        err_wdf_d = err_wdf_q || wd_bad;

        pv_d    = pv_q;
        pd_d    = pd_q;
        pv_d[0] = exec_rd;
        if (exec_rd) begin
            pd_d[0] = mem_q[head_idx];
        end
        for (int i = 1; i < RD_LATENCY; i++) begin
            pv_d[i] = pv_q[i-1];
            pd_d[i] = pd_q[i-1];
        end

        rd_vld_d  = pv_q[RD_LATENCY-1];
        rd_data_d = pv_q[RD_LATENCY-1] ? pd_q[RD_LATENCY-1] : rd_data_q;
    end

    // Control registers with synchronous reset
    always_ff @(posedge ui_clk) begin
        if (ui_clk_sync_rst) begin
            cq_rd_q   <= '0;
            cq_wr_q   <= '0;
            cq_cnt_q  <= '0;
            wq_rd_q   <= '0;
            wq_wr_q   <= '0;
            wq_cnt_q  <= '0;
            cal_cnt_q <= '0;
            calib_q   <= 1'b0;
            thr_q     <= '0;
            rdy_q     <= 1'b0;
            wdf_rdy_q <= 1'b0;
            err_cmd_q <= 1'b0;
            err_wdf_q <= 1'b0;
            rd_vld_q  <= 1'b0;
            rd_data_q <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                pv_q[i] <= 1'b0;
                pd_q[i] <= '0;
            end
        end else begin
            cq_rd_q   <= cq_rd_d;
            cq_wr_q   <= cq_wr_d;
            cq_cnt_q  <= cq_cnt_d;
            wq_rd_q   <= wq_rd_d;
            wq_wr_q   <= wq_wr_d;
            wq_cnt_q  <= wq_cnt_d;
            cal_cnt_q <= cal_cnt_d;
            calib_q   <= calib_d;
            thr_q     <= thr_d;
            rdy_q     <= rdy_d;
            wdf_rdy_q <= wdf_rdy_d;
            err_cmd_q <= err_cmd_d;
            err_wdf_q <= err_wdf_d;
            rd_vld_q  <= rd_vld_d;
            rd_data_q <= rd_data_d;
            for (int i = 0; i < RD_LATENCY; i++) begin
                pv_q[i] <= pv_d[i];
                pd_q[i] <= pd_d[i];
            end
        end
    end

    // Queue payload slots and burst RAM; never reset, writes blocked during reset
    always_ff @(posedge ui_clk) begin
        if (!ui_clk_sync_rst) begin
            if (cmd_push) begin
                cq_cmd_q[cq_wr_q] <= app_cmd;
                cq_idx_q[cq_wr_q] <= in_idx;
            end
            if (wd_push) begin
                wq_data_q[wq_wr_q] <= app_wdf_data;
                wq_mask_q[wq_wr_q] <= app_wdf_mask;
            end
            if (exec_wr) begin
                for (int b = 0; b < MASK_WIDTH; b++) begin
                    if (!wq_mask_q[wq_rd_q][b]) begin
                        mem_q[head_idx][b*8 +: 8] <= wq_data_q[wq_rd_q][b*8 +: 8];
                    end
                end
            end
        end
    end

    assign app_rdy             = rdy_q;
    assign app_wdf_rdy         = wdf_rdy_q;
    assign app_rd_data         = rd_data_q;
    assign app_rd_data_valid   = rd_vld_q;
    assign app_rd_data_end     = rd_vld_q;
    assign init_calib_complete = calib_q;
    assign err_cmd             = err_cmd_q;
    assign err_wdf             = err_wdf_q;

endmodule

// File: tb/tb_mig_ui_responder.sv
// Bench for mig_ui_responder: two instances (no throttle / BUSY_PERIOD=5),
// one held in reset while the other is exercised, checked against a
// queue-based scoreboard of the app_* protocol.
module tb_mig_ui_responder;

    localparam int unsigned AW    = 29;
    localparam int unsigned DW    = 256;
    localparam int unsigned MW    = 32;
    localparam int unsigned DL    = 6;
    localparam int unsigned LAT   = 4;
    localparam int unsigned CAL   = 64;
    localparam int unsigned DEPTH = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, sel;
    logic [AW-1:0] app_addr;
    logic [2:0]    app_cmd;
    logic          app_en;
    logic [DW-1:0] app_wdf_data;
    logic [MW-1:0] app_wdf_mask;
    logic          app_wdf_wren, app_wdf_end;

    logic rst0, rst5;
    logic rdy0, wrdy0, v0, e0, cal0, ec0, ew0;
    logic rdy5, wrdy5, v5, e5, cal5, ec5, ew5;
    logic [DW-1:0] d0, d5;
    logic m_rdy, m_wrdy, m_vld, m_end, m_cal, m_ecmd, m_ewdf;
    logic [DW-1:0] m_data;

    assign rst0   = rst | sel;
    assign rst5   = rst | ~sel;
    assign m_rdy  = sel ? rdy5  : rdy0;
    assign m_wrdy = sel ? wrdy5 : wrdy0;
    assign m_vld  = sel ? v5    : v0;
    assign m_end  = sel ? e5    : e0;
    assign m_cal  = sel ? cal5  : cal0;
    assign m_ecmd = sel ? ec5   : ec0;
    assign m_ewdf = sel ? ew5   : ew0;
    assign m_data = sel ? d5    : d0;

    mig_ui_responder #(.BUSY_PERIOD(0)) u_dut0 (
        .ui_clk(clk), .ui_clk_sync_rst(rst0), .app_addr(app_addr), .app_cmd(app_cmd),
        .app_en(app_en), .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask),
        .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end), .app_rdy(rdy0),
        .app_wdf_rdy(wrdy0), .app_rd_data(d0), .app_rd_data_valid(v0),
        .app_rd_data_end(e0), .init_calib_complete(cal0), .err_cmd(ec0), .err_wdf(ew0));

    mig_ui_responder #(.BUSY_PERIOD(5)) u_dut5 (
        .ui_clk(clk), .ui_clk_sync_rst(rst5), .app_addr(app_addr), .app_cmd(app_cmd),
        .app_en(app_en), .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask),
        .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end), .app_rdy(rdy5),
        .app_wdf_rdy(wrdy5), .app_rd_data(d5), .app_rd_data_valid(v5),
        .app_rd_data_end(e5), .init_calib_complete(cal5), .err_cmd(ec5), .err_wdf(ew5));

    typedef struct {
        logic [DW-1:0] d;
        int            acc_cyc;
        bit            lat;
    } exp_t;

    exp_t          exp_q [$];
    logic [DL-1:0] pend_w [$];
    logic [DW-1:0] pend_d [$];
    logic [MW-1:0] pend_m [$];
    logic [DW-1:0] mmem [DEPTH];
    bit            err_cmd_m, err_wdf_m, lat_mode, thr_chk, have_low;
    logic [DW-1:0] last_rd;
    int            cyc = 0;
    int            n_cmp = 0, n_bad = 0, n_valid = 0, last_low = 0, n_low = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Byte-enable rule: mask bit set keeps the old byte
    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nd,
                                            input logic [MW-1:0] m);
        logic [DW-1:0] r;
        r = old;
        for (int b = 0; b < MW; b++) if (!m[b]) r[b*8 +: 8] = nd[b*8 +: 8];
        return r;
    endfunction

    function automatic logic [DW-1:0] rnd256();
        logic [DW-1:0] r;
        for (int i = 0; i < DW/32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: inputs and ready are stable at the falling edge, so
    // handshakes for the coming rising edge are decided here.
    always @(negedge clk) begin
        exp_t          e;
        logic [DL-1:0] ix;
        if (rst) begin
            exp_q.delete(); pend_w.delete(); pend_d.delete(); pend_m.delete();
            err_cmd_m = 0; err_wdf_m = 0; last_rd = '0; have_low = 0;
        end else begin
            if (m_vld || m_end) check("rd_end", m_end, m_vld);
            if (m_vld) begin
                n_valid++;
                if (exp_q.size() == 0) check("unexpected_valid", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    check("rd_data", m_data, e.d);
                    if (e.lat) check("rd_latency", cyc - e.acc_cyc, LAT + 1);
                    last_rd = e.d;
                end
            end else if (m_cal) begin
                check("rd_hold", m_data, last_rd);
            end
            if (thr_chk && m_cal && !m_rdy) begin
                if (have_low) check("rdy_period", cyc - last_low, 5);
                last_low = cyc; have_low = 1; n_low++;
            end
            if (app_wdf_wren && m_wrdy) begin
                if (app_wdf_end) begin
                    pend_d.push_back(app_wdf_data); pend_m.push_back(app_wdf_mask);
                end else err_wdf_m = 1;
            end
            while (pend_w.size() > 0 && pend_d.size() > 0) begin
                ix = pend_w.pop_front();
                mmem[ix] = merge(mmem[ix], pend_d.pop_front(), pend_m.pop_front());
            end
            if (app_en && m_rdy) begin
                ix = app_addr[3 +: DL];
                if (app_cmd == 3'd0) pend_w.push_back(ix);
                else if (app_cmd == 3'd1) begin
                    e.d = mmem[ix]; e.acc_cyc = cyc + 1; e.lat = lat_mode;
                    exp_q.push_back(e);
                end else err_cmd_m = 1;
            end
            while (pend_w.size() > 0 && pend_d.size() > 0) begin
                ix = pend_w.pop_front();
                mmem[ix] = merge(mmem[ix], pend_d.pop_front(), pend_m.pop_front());
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Present a command and/or a write beat; each is held until accepted
    task automatic issue(input bit has_c, input logic [2:0] cmd, input logic [AW-1:0] addr,
                         input bit has_d, input bit dend, input logic [DW-1:0] d,
                         input logic [MW-1:0] m);
        bit ce, de;
        int t;
        t = 0;
        app_en = has_c; app_cmd = cmd; app_addr = addr;
        app_wdf_wren = has_d; app_wdf_end = has_d & dend; app_wdf_data = d; app_wdf_mask = m;
        while ((app_en || app_wdf_wren) && t < 200) begin
            @(negedge clk);
            ce = app_en && m_rdy;
            de = app_wdf_wren && m_wrdy;
            @(posedge clk); #1;
            if (ce) app_en = 1'b0;
            if (de) begin app_wdf_wren = 1'b0; app_wdf_end = 1'b0; end
            t++;
        end
        if (t >= 200) begin
            check("issue_timeout", 1, 0);
            app_en = 1'b0; app_wdf_wren = 1'b0; app_wdf_end = 1'b0;
        end
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [MW-1:0] m);
        issue(1, 3'd0, a, 1, 1, d, m);
    endtask

    task automatic rd(input logic [AW-1:0] a);
        issue(1, 3'd1, a, 0, 0, '0, '0);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() > 0 && t < 100) begin tick(1); t++; end
        check("drain", exp_q.size(), 0);
        tick(2);
    endtask

    initial begin
        int vb;
        logic [DW-1:0] dv;
        rst = 1; sel = 0; lat_mode = 0; thr_chk = 0;
        app_en = 0; app_cmd = '0; app_addr = '0;
        app_wdf_wren = 0; app_wdf_end = 0; app_wdf_data = '0; app_wdf_mask = '0;

        // Calibration window after 70 reset cycles
        repeat (70) @(posedge clk);
        #1 rst = 0;
        for (int k = 0; k < 70; k++) begin
            @(negedge clk);
            if (k == 0) begin
                check("rst_valid", m_vld, 0);
                check("rst_rd_data", m_data, 0);
                check("rst_errs", {m_ecmd, m_ewdf}, 0);
            end
            check("calib", m_cal, k >= CAL);
            check("rdy_calib", m_rdy, k >= CAL);
            check("wdf_rdy_calib", m_wrdy, k >= CAL);
        end
        @(posedge clk); #1;

        // Give every RAM word a known value
        for (int i = 0; i < DEPTH; i++) wr(AW'(i*8), rnd256(), '0);

        // 20 bursts written then read back in order
        for (int i = 0; i < 20; i++) wr(AW'(i*8), DW'(2*i), '0);
        vb = n_valid;
        for (int i = 0; i < 20; i++) rd(AW'(i*8));
        drain();
        check("valid_count_20", n_valid - vb, 20);

        // Byte mask: only byte 0 overwritten
        wr(AW'(0), '1, '0);
        wr(AW'(0), '0, 32'hFFFF_FFFE);
        rd(AW'(0));
        drain();
        dv = '1; dv[7:0] = 8'h00;
        check("mask_result", m_data, dv);

        // Write data two cycles ahead of its command, then timed read
        issue(0, 3'd0, '0, 1, 1, DW'(256'hA5A5), '0);
        tick(2);
        issue(1, 3'd0, AW'(16*8), 0, 0, '0, '0);
        lat_mode = 1;
        rd(AW'(16*8));
        lat_mode = 0;
        drain();
        check("early_data", m_data, DW'(256'hA5A5));

        // Four writes without data fill the command queue
        for (int i = 0; i < 4; i++) issue(1, 3'd0, AW'((40+i)*8), 0, 0, '0, '0);
        @(negedge clk);
        check("rdy_full", m_rdy, 0);
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) issue(0, 3'd0, '0, 1, 1, DW'(1000+i), '0);
        for (int i = 0; i < 4; i++) rd(AW'((40+i)*8));
        drain();

        // Illegal command and a beat without app_wdf_end
        issue(1, 3'd2, AW'(8), 0, 0, '0, '0);
        @(negedge clk);
        check("err_cmd_set", m_ecmd, 1);
        @(posedge clk); #1;
        rd(AW'(8));
        issue(0, 3'd0, '0, 1, 0, DW'(256'hBAD), '0);
        @(negedge clk);
        check("err_wdf_set", m_ewdf, 1);
        @(posedge clk); #1;
        wr(AW'(8), DW'(256'h600D), '0);
        rd(AW'(8));
        drain();
        check("bad_beat_dropped", m_data, DW'(256'h600D));
        check("err_cmd_sticky", m_ecmd, 1);

        // Randomized traffic with address wrap and ignored low bits
        for (int n = 0; n < 300; n++) begin
            int op;
            op = int'($urandom_range(0, 9));
            if (op < 4)       wr(AW'($urandom), rnd256(), ($urandom_range(0, 1) != 0) ? MW'($urandom) : '0);
            else if (op < 8)  rd(AW'($urandom));
            else if (op == 8) issue(1, 3'($urandom_range(2, 7)), AW'($urandom), 0, 0, '0, '0);
            else              tick(int'($urandom_range(1, 3)));
        end
        drain();
        @(negedge clk);
        check("err_cmd_rand", m_ecmd, err_cmd_m);
        check("err_wdf_rand", m_ewdf, err_wdf_m);
        @(posedge clk); #1;

        // Reset with four reads in flight
        for (int i = 0; i < 4; i++) rd(AW'(i*8));
        rst = 1;
        vb = n_valid;
        tick(3);
        rst = 0;
        @(negedge clk);
        check("calib_restart", m_cal, 0);
        check("err_cleared", {m_ecmd, m_ewdf}, 0);
        @(posedge clk); #1;
        tick(20);
        check("no_valid_after_rst", n_valid - vb, 0);
        tick(50);

        // Throttled instance: streaming writes then 40 streaming reads
        rst = 1; sel = 1;
        tick(3);
        rst = 0;
        tick(CAL + 2);
        thr_chk = 1;
        for (int i = 0; i < 40; i++) wr(AW'(i*8), rnd256(), '0);
        vb = n_valid;
        for (int i = 0; i < 40; i++) rd(AW'(i*8));
        drain();
        thr_chk = 0;
        check("valid_count_40", n_valid - vb, 40);
        check("throttle_seen", n_low >= 16, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
